// File: rtl/class_argmax.sv
// ----------------------------------------------------------------------------
// class_argmax
//
// Running arg-max over one frame of signed class scores. Scores arrive one
// per accepted beat, in class order. After the last class of a frame the
// winning index and its score are held behind a valid/ready handshake until
// the consumer takes them, then the block returns to collecting.
//
// Optional feature macro: CLASS_BIAS_EN
//   defined   -> bias_in port exists; each score is in_value + bias_in,
//                computed one bit wider and saturated to the DATA_W range.
//   undefined -> no bias_in port, score is in_value unchanged.
//
// Parameters
//   NUM_CLASSES  scores per frame (2..16)
//   DATA_W       score width, two's complement
//   IDX_W        class index width
//
// Ports
//   clk          clock, all logic on posedge
//   GlobalReset  synchronous active-high reset
//   in_valid     in_value carries a score this cycle
//   in_value     signed score for class in_index
//   in_ready     block accepts a score this cycle (state decode only)
//   bias_in      signed per-class bias (CLASS_BIAS_EN only)
//   out_valid    result pending
//   out_ready    consumer takes result
//   class_out    winning class index
//   max_value    winning (biased, if enabled) score
//   in_index     index of the class expected next (bias-ROM address)
// ----------------------------------------------------------------------------
module class_argmax #(
    parameter int NUM_CLASSES = 10,
    parameter int DATA_W      = 27,
    parameter int IDX_W       = 4
) (
    input  logic              clk,
    input  logic              GlobalReset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_value,
    output logic              in_ready,
`ifdef CLASS_BIAS_EN
    input  logic [DATA_W-1:0] bias_in,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDX_W-1:0]  class_out,
    output logic [DATA_W-1:0] max_value,
    output logic [IDX_W-1:0]  in_index
);

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        RESULT  = 1'b1
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

    state_t                   state_reg, state_next;
    logic [IDX_W-1:0]         index_reg, index_next;
    logic [IDX_W-1:0]         class_reg, class_next;
    logic signed [DATA_W-1:0] max_reg,   max_next;

    logic                     accept;
    logic                     last_beat;
    logic signed [DATA_W-1:0] score;

    // ------------------------------------------------------------------
    // Score formation
    // ------------------------------------------------------------------
`ifdef CLASS_BIAS_EN
    localparam logic signed [DATA_W-1:0] SCORE_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] SCORE_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    logic signed [DATA_W:0] biased_sum;

    always_comb begin
        biased_sum = $signed({in_value[DATA_W-1], in_value})
                   + $signed({bias_in[DATA_W-1], bias_in});
        // The top two bits disagree only when the sum left the DATA_W range;
        // the extra sign bit tells which rail to clamp to.
        if (biased_sum[DATA_W] != biased_sum[DATA_W-1]) begin
            score = biased_sum[DATA_W] ? SCORE_MIN : SCORE_MAX;
        end else begin
            score = biased_sum[DATA_W-1:0];
        end
    end
`else
    always_comb begin
        score = $signed(in_value);
    end
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (GlobalReset) begin
            state_reg <= COLLECT;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            COLLECT: if (accept && last_beat) state_next = RESULT;
            RESULT:  if (out_ready)           state_next = COLLECT;
            default:                          state_next = COLLECT;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    // in_ready is held low during reset so nothing is taken before the
    // state register is known to be in COLLECT.
    always_comb begin
        in_ready  = (state_reg == COLLECT) && !GlobalReset;
        out_valid = (state_reg == RESULT);
    end

    assign accept    = in_valid && in_ready;
    assign last_beat = (index_reg == LAST_IDX);

    // ------------------------------------------------------------------
    // Running maximum datapath
    // ------------------------------------------------------------------
    always_comb begin
        index_next = index_reg;
        class_next = class_reg;
        max_next   = max_reg;
        if (accept) begin
            if (index_reg == '0) begin
                // First class of a frame seeds the maximum unconditionally.
                max_next   = score;
                class_next = '0;
            end else if (score > max_reg) begin
                // Strict compare: ties keep the earlier (lower) index.
                max_next   = score;
                class_next = index_reg;
            end
            index_next = last_beat ? '0 : index_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (GlobalReset) begin
            index_reg <= '0;
            class_reg <= '0;
            max_reg   <= '0;
        end else begin
            index_reg <= index_next;
            class_reg <= class_next;
            max_reg   <= max_next;
        end
    end

    assign class_out = class_reg;
    assign max_value = max_reg;
    assign in_index  = index_reg;

endmodule

// File: tb/tb_class_argmax.sv
// ----------------------------------------------------------------------------
// tb_class_argmax
//
// Directed bench for class_argmax. Inputs are driven and outputs sampled on
// the falling clock edge, so every beat driven at one negedge is taken by the
// following posedge and its effect is visible at the next negedge.
// Define CLASS_BIAS_EN for both bench and RTL to exercise the bias path.
// ----------------------------------------------------------------------------
module tb_class_argmax;

    localparam int NUM_CLASSES = 10;
    localparam int DATA_W      = 27;
    localparam int IDX_W       = 4;

    logic              clk;
    logic              GlobalReset;
    logic              in_valid;
    logic [DATA_W-1:0] in_value;
    logic              in_ready;
    logic              out_valid;
    logic              out_ready;
    logic [IDX_W-1:0]  class_out;
    logic [DATA_W-1:0] max_value;
    logic [IDX_W-1:0]  in_index;
`ifdef CLASS_BIAS_EN
    logic [DATA_W-1:0] bias_val;
`endif

    int checks;
    int failures;

    class_argmax #(
        .NUM_CLASSES (NUM_CLASSES),
        .DATA_W      (DATA_W),
        .IDX_W       (IDX_W)
    ) dut (
        .clk         (clk),
        .GlobalReset (GlobalReset),
        .in_valid    (in_valid),
        .in_value    (in_value),
        .in_ready    (in_ready),
`ifdef CLASS_BIAS_EN
        .bias_in     (bias_val),
`endif
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .class_out   (class_out),
        .max_value   (max_value),
        .in_index    (in_index)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one beat and advance to the next falling edge.
    task automatic drive_beat(input int v);
        in_valid = 1'b1;
        in_value = DATA_W'(v);
        @(negedge clk);
    endtask

    task automatic test_reset;
        GlobalReset = 1'b1;
        in_valid    = 1'b0;
        in_value    = '0;
        out_ready   = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_in_ready got=%0b want=0", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0 || class_out !== 4'd0 || max_value !== 27'd0 || in_index !== 4'd0) begin
            failures++;
            $display("FAIL reset_state got ov=%0b cls=%0d max=%0h idx=%0d want 0/0/0/0",
                     out_valid, class_out, max_value, in_index);
        end
        GlobalReset = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_in_ready got=%0b want=1", in_ready);
        end
        @(negedge clk);
        $display("test_reset done");
    endtask

    task automatic test_basic;
        int vals[10];
        vals = '{5, 3, 9, 1, 0, 2, 8, 7, 4, 6};
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive_beat(vals[i]);
            if (i == 2) begin
                checks++;
                if (in_index !== 4'd3) begin
                    failures++;
                    $display("FAIL basic_in_index got=%0d want=3", in_index);
                end
            end
            if (i == 8) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL basic_early_valid got=%0b want=0", out_valid);
                end
            end
        end
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL basic_result_handshake got ov=%0b ir=%0b want ov=1 ir=0", out_valid, in_ready);
        end
        checks++;
        if (class_out !== 4'd2 || $signed(max_value) !== 27'sd9) begin
            failures++;
            $display("FAIL basic_result got cls=%0d max=%0d want cls=2 max=9", class_out, $signed(max_value));
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || in_index !== 4'd0) begin
            failures++;
            $display("FAIL basic_return got ov=%0b ir=%0b idx=%0d want 0/1/0", out_valid, in_ready, in_index);
        end
        $display("test_basic done cls=%0d max=%0d", class_out, $signed(max_value));
    endtask

    // Runs one frame with out_ready high and checks the published result.
    task automatic test_frame(input string name, input int vals[10], input int exp_cls, input int exp_max);
        logic [DATA_W-1:0] want_max;
        want_max = DATA_W'(exp_max);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) drive_beat(vals[i]);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || class_out !== IDX_W'(exp_cls) || max_value !== want_max) begin
            failures++;
            $display("FAIL %s got ov=%0b cls=%0d max=%0d want ov=1 cls=%0d max=%0d",
                     name, out_valid, class_out, $signed(max_value), exp_cls, exp_max);
        end
        @(negedge clk);
        $display("%s done cls=%0d", name, class_out);
    endtask

    task automatic test_values;
        test_frame("neg_frame",  '{-100, -7, -50, -20, -30, -40, -60, -70, -80, -9}, 1, -7);
        test_frame("tie_frame",  '{4, 4, 4, 4, 4, 4, 4, 4, 4, 4}, 0, 4);
        test_frame("last_frame", '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9}, 9, 9);
        test_frame("late_tie",   '{1, 7, 2, 3, 7, 7, 0, 7, 6, 7}, 1, 7);
        test_frame("extremes",   '{-67108864, -67108864, -67108864, -67108864, -67108864,
                                   67108863, -67108864, 67108863, -67108864, -67108864}, 5, 67108863);
    endtask

    task automatic test_backpressure;
        int a[10];
        int b[10];
        a = '{1, 2, 3, 30, 4, 5, 6, 7, 8, 9};
        b = '{11, 12, 13, 14, 15, 16, 17, 18, 19, 20};
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) drive_beat(a[i]);
        in_valid = 1'b1;
        in_value = DATA_W'(b[0]);
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || class_out !== 4'd3 ||
                $signed(max_value) !== 27'sd30 || in_index !== 4'd0) begin
                failures++;
                $display("FAIL bp_hold cyc=%0d got ir=%0b ov=%0b cls=%0d max=%0d idx=%0d want 0/1/3/30/0",
                         c, in_ready, out_valid, class_out, $signed(max_value), in_index);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || in_index !== 4'd0) begin
            failures++;
            $display("FAIL bp_release got ov=%0b ir=%0b idx=%0d want 0/1/0", out_valid, in_ready, in_index);
        end
        for (int i = 0; i < 10; i++) drive_beat(b[i]);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || class_out !== 4'd9 || $signed(max_value) !== 27'sd20) begin
            failures++;
            $display("FAIL bp_next_frame got ov=%0b cls=%0d max=%0d want 1/9/20",
                     out_valid, class_out, $signed(max_value));
        end
        @(negedge clk);
        $display("test_backpressure done");
    endtask

    task automatic test_reset_midframe;
        int a[6];
        a = '{3, 1000, 2, 5, 6, 7};
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) drive_beat(a[i]);
        in_valid = 1'b0;
        checks++;
        if (in_index !== 4'd6) begin
            failures++;
            $display("FAIL midreset_pre_idx got=%0d want=6", in_index);
        end
        GlobalReset = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL midreset_in_ready got=%0b want=0", in_ready);
        end
        @(negedge clk);
        GlobalReset = 1'b0;
        checks++;
        if (in_index !== 4'd0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL midreset_clear got idx=%0d ov=%0b want 0/0", in_index, out_valid);
        end
        test_frame("midreset_fresh", '{1, 2, 3, 4, 50, 6, 7, 8, 9, 10}, 4, 50);
    endtask

    task automatic test_random_gaps;
        int v[10];
        int best;
        int best_idx;
        for (int f = 0; f < 100; f++) begin
            for (int i = 0; i < 10; i++) v[i] = int'($urandom_range(0, 15)) - 8;
            best = v[0];
            best_idx = 0;
            for (int i = 1; i < 10; i++) begin
                if (v[i] > best) begin
                    best = v[i];
                    best_idx = i;
                end
            end
            out_ready = 1'b1;
            for (int i = 0; i < 10; i++) begin
                while ($urandom_range(0, 1) == 0) begin
                    in_valid = 1'b0;
                    in_value = DATA_W'($urandom_range(0, 1000));
                    @(negedge clk);
                end
                drive_beat(v[i]);
            end
            in_valid = 1'b0;
            checks++;
            if (out_valid !== 1'b1 || class_out !== IDX_W'(best_idx) || max_value !== DATA_W'(best)) begin
                failures++;
                $display("FAIL rand_frame f=%0d got ov=%0b cls=%0d max=%0d want ov=1 cls=%0d max=%0d",
                         f, out_valid, class_out, $signed(max_value), best_idx, best);
            end
            @(negedge clk);
        end
        $display("test_random_gaps done");
    endtask

`ifdef CLASS_BIAS_EN
    task automatic drive_bias_beat(input int v, input int b);
        bias_val = DATA_W'(b);
        drive_beat(v);
    endtask

    task automatic test_bias;
        int v[10];
        int b[10];
        // Positive saturation at class 0.
        v = '{67108863, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        b = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        for (int i = 0; i < 10; i++) drive_bias_beat(v[i], b[i]);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || class_out !== 4'd0 || max_value !== 27'h3FFFFFF) begin
            failures++;
            $display("FAIL bias_pos_sat got ov=%0b cls=%0d max=%0h want 1/0/3ffffff", out_valid, class_out, max_value);
        end
        @(negedge clk);
        // Negative saturation on every class: all tie at the minimum.
        for (int i = 0; i < 10; i++) drive_bias_beat(-67108864, -1);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || class_out !== 4'd0 || max_value !== 27'h4000000) begin
            failures++;
            $display("FAIL bias_neg_sat got ov=%0b cls=%0d max=%0h want 1/0/4000000", out_valid, class_out, max_value);
        end
        @(negedge clk);
        // Bias lifts class 7 (90+20) above class 2 (100).
        v = '{10, 20, 100, 30, 40, 50, 60, 90, 70, 80};
        b = '{0, 0, 0, 0, 0, 0, 0, 20, 0, 0};
        for (int i = 0; i < 10; i++) drive_bias_beat(v[i], b[i]);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || class_out !== 4'd7 || $signed(max_value) !== 27'sd110) begin
            failures++;
            $display("FAIL bias_lift got ov=%0b cls=%0d max=%0d want 1/7/110", out_valid, class_out, $signed(max_value));
        end
        @(negedge clk);
        bias_val = '0;
        $display("test_bias done");
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
`ifdef CLASS_BIAS_EN
        bias_val = '0;
`endif
        test_reset();
        test_basic();
        test_values();
        test_backpressure();
        test_reset_midframe();
        test_random_gaps();
`ifdef CLASS_BIAS_EN
        test_bias();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/class_argmax.md
# class_argmax

Downstream consumer of the dot-product stage. Receives one signed 27-bit dot-product score per output class, in class order, and tracks the running maximum. After the last class of a frame it presents the winning class index and its score through a valid/ready handshake. Sits between the dot-product datapath and the result/readout logic of the classifier.

## Interface
- NUM_CLASSES, 10, scores per frame (2..16)
- DATA_W, 27, score width, two's complement (matches dot-product output)
- IDX_W, 4, class index width; ceil(log2(NUM_CLASSES)) minimum
- clk  input  1  single clock; all logic on posedge
- GlobalReset  input  1  synchronous, active-high reset
- in_valid  input  1  in_value carries a score this cycle
- in_value  input  DATA_W  signed score for class in_index order
- in_ready  output  1  block accepts a score this cycle
- bias_in  input  DATA_W  signed per-class bias (present only with CLASS_BIAS_EN)
- out_valid  output  1  result pending
- out_ready  input  1  consumer takes result
- class_out  output  IDX_W  winning class index
- max_value  output  DATA_W  winning (biased, if enabled) score
- in_index  output  IDX_W  index of the class expected next (debug/bias-ROM address)

## Operation
- States: COLLECT, RESULT.
- COLLECT: in_ready=1. Beat accepted when in_valid && in_ready. Each beat: score s = in_value (or biased score, see Configuration); in_index increments.
- Beat with in_index=0: load max_value=s, class_out=0 unconditionally.
- Beat with in_index>0: if s > max_value (signed, strict) load max_value=s, class_out=in_index; else hold. Ties keep the lower index.
- Beat with in_index=NUM_CLASSES-1: after update, in_index wraps to 0, state -> RESULT.
- RESULT: in_ready=0, out_valid=1, class_out/max_value stable. out_valid && out_ready -> COLLECT next cycle; out_valid drops next cycle.
- in_valid while in_ready=0: ignored, no state change; upstream must hold data.
- Gaps (in_valid=0) inside a frame allowed; no timeout.
- GlobalReset at any point: partial frame or pending result discarded.

## Timing
- Reset values (cycle after GlobalReset sampled high): state=COLLECT, in_index=0, out_valid=0, class_out=0, max_value=0. in_ready=0 while GlobalReset is high, 1 from the first cycle after.
- in_ready is a combinational decode of state only; no dependency on in_valid or out_ready.
- Latency: out_valid rises on the clock edge that accepts the last beat (visible the following cycle, one cycle after the last beat).
- Max throughput: NUM_CLASSES + 1 cycles per frame with out_ready held high (N accept cycles + 1 RESULT cycle). No acceptance during RESULT.
- out_ready ignored in COLLECT.
- class_out/max_value may change during COLLECT; only meaningful while out_valid=1.

## Configuration
- CLASS_BIAS_EN defined: bias_in port exists; s = sat(in_value + bias_in), computed at DATA_W+1 bits and saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1]. bias_in sampled in the same cycle as its score; upstream addresses bias via in_index.
- CLASS_BIAS_EN undefined: no bias_in port, no adder; s = in_value.

## Test plan
- Reset then scores 5,3,9,1,0,2,8,7,4,6 with in_valid high every cycle, out_ready=1 -> out_valid one cycle after 10th beat, class_out=2, max_value=9, out_valid high exactly 1 cycle, in_ready back 1 cycle later.
- All negative scores -100,-7,-50,...,-9 (min others) -> class_out=1, max_value=-7; tie scores 4,4,4,... -> class_out=0.
- Backpressure: out_ready=0 for 5 cycles after result, in_valid held high with new frame -> in_ready=0, result stable, no beats consumed; frame accepted starting the cycle after out_ready handshake.
- GlobalReset pulsed after beat 6 of a frame, then a fresh full frame -> result reflects only the fresh frame; in_index restarts at 0.
- Random in_valid gaps (50%) over 100 frames vs reference model -> every class_out/max_value match, lowest-index tie rule held.
- CLASS_BIAS_EN: in_value=0x3FFFFFF (max) with bias_in=1 -> max_value saturates to 0x3FFFFFF; in_value=-2^26 with bias_in=-1 -> saturates to 0x4000000; bias lifts class 7 above class 2 and class_out=7.
